// File: rtl/imem_byte_loader.sv
// Host-to-core program loader: packs strobed bytes little-endian into 32-bit
// words, writes them to instruction memory and holds the CPU in reset while loading.
module imem_byte_loader #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            byte_in,
    input  logic                  byte_stb,
    input  logic                  load_mode,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  cpu_rst_n,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output logic                  overflow,
    output logic                  partial
);

    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned LOW_W  = WIDTH - 8;

    localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_stb_s1;
    logic                  r_stb_s2;
    logic                  r_stb_d;
    logic                  r_mode_s1;
    logic                  r_mode_s2;
    logic [1:0]            r_k;
    logic [LOW_W-1:0]      r_word;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [WIDTH-1:0]      r_wr_data;
    logic                  r_cpu_rst_n;
    logic [CNT_W-1:0]      r_words_loaded;
    logic                  r_overflow;
    logic                  r_partial;

    logic                  w_stb_edge;
    logic                  w_enter_load;

    assign w_stb_edge   = r_stb_s2 & ~r_stb_d;
    assign w_enter_load = r_mode_s2 && (r_state != S_LOAD);

    // Two-flop synchronisers for the asynchronous host pins plus strobe edge history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stb_s1  <= 1'b0;
            r_stb_s2  <= 1'b0;
            r_stb_d   <= 1'b0;
            r_mode_s1 <= 1'b0;
            r_mode_s2 <= 1'b0;
        end else begin
            r_stb_s1  <= byte_stb;
            r_stb_s2  <= r_stb_s1;
            r_stb_d   <= r_stb_s2;
            r_mode_s1 <= load_mode;
            r_mode_s2 <= r_mode_s1;
        end
    end

    // Session FSM with byte packing, write pulse, address/count tracking and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_k            <= 2'd0;
            r_word         <= '0;
            r_wr_en        <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_cpu_rst_n    <= 1'b0;
            r_words_loaded <= '0;
            r_overflow     <= 1'b0;
            r_partial      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;

            // Address and count advance in the cycle after the write pulse
            if (r_wr_en) begin
                r_words_loaded <= r_words_loaded + CNT_W'(1);
                if (r_wr_addr != LAST_ADDR) begin
                    r_wr_addr <= r_wr_addr + ADDR_WIDTH'(1);
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (r_mode_s2) begin
                        r_state <= S_LOAD;
                    end else begin
                        r_state     <= S_RUN;
                        r_cpu_rst_n <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!r_mode_s2) begin
                        // Leaving LOAD drops any pending bytes; a same-cycle strobe is ignored
                        r_state     <= S_RUN;
                        r_cpu_rst_n <= 1'b1;
                        r_k         <= 2'd0;
                        if (r_k != 2'd0) begin
                            r_partial <= 1'b1;
                        end
                    end else if (w_stb_edge) begin
                        r_k <= r_k + 2'd1;
                        case (r_k)
                            2'd0: r_word[7:0]   <= byte_in;
                            2'd1: r_word[15:8]  <= byte_in;
                            2'd2: r_word[23:16] <= byte_in;
                            default: begin
                                if (r_words_loaded == FULL_CNT) begin
                                    r_overflow <= 1'b1;
                                end else begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_data <= {byte_in, r_word};
                                end
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    if (r_mode_s2) begin
                        r_state     <= S_LOAD;
                        r_cpu_rst_n <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_cpu_rst_n <= 1'b0;
                end
            endcase

            // Starting a session clears position, counters and flags
            if (w_enter_load) begin
                r_k            <= 2'd0;
                r_wr_addr      <= '0;
                r_words_loaded <= '0;
                r_overflow     <= 1'b0;
                r_partial      <= 1'b0;
            end
        end
    end

    assign wr_en        = r_wr_en;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign cpu_rst_n    = r_cpu_rst_n;
    assign words_loaded = r_words_loaded;
    assign overflow     = r_overflow;
    assign partial      = r_partial;

endmodule

// File: tb/tb_imem_byte_loader.sv
// Scoreboard bench for imem_byte_loader: stimulus queues expected writes,
// a negedge monitor pops and compares on every write pulse.
module tb_imem_byte_loader;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned AW    = 6;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [7:0]       byte_in;
    logic             byte_stb;
    logic             load_mode;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;
    logic             cpu_rst_n;
    logic [AW:0]      words_loaded;
    logic             overflow;
    logic             partial;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  exp_addr = 0;
    int  n_pass   = 0;
    int  n_total  = 0;

    imem_byte_loader #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_in      (byte_in),
        .byte_stb     (byte_stb),
        .load_mode    (load_mode),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_rst_n    (cpu_rst_n),
        .words_loaded (words_loaded),
        .overflow     (overflow),
        .partial      (partial)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write: got addr %0d data 0x%h, expected no write", wr_addr, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(wr_addr), 64'(mon_e.addr));
                check("wr_data", 64'(wr_data), 64'(mon_e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        byte_in  = b;
        byte_stb = 1'b1;
        repeat (2) @(negedge clk);
        byte_stb = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input bit expect_wr);
        if (expect_wr) begin
            exp_q.push_back({AW'(exp_addr), w});
            exp_addr++;
        end
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    // Change load_mode and verify cpu_rst_n follows exactly 3 edges later
    task automatic set_mode(input logic m, input logic exp_cpu);
        load_mode = m;
        if (m) exp_addr = 0;
        repeat (2) @(negedge clk);
        check("cpu_rst_n_before_mode", 64'(cpu_rst_n), 64'(!exp_cpu));
        @(negedge clk);
        check("cpu_rst_n_after_mode", 64'(cpu_rst_n), 64'(exp_cpu));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},        64'(wr_en),        64'd0);
        check({tag, "_wr_addr"},      64'(wr_addr),      64'd0);
        check({tag, "_wr_data"},      64'(wr_data),      64'd0);
        check({tag, "_cpu_rst_n"},    64'(cpu_rst_n),    64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'd0);
        check({tag, "_overflow"},     64'(overflow),     64'd0);
        check({tag, "_partial"},      64'(partial),      64'd0);
    endtask

    initial begin
        bit found;
        rst_n     = 1'b0;
        byte_in   = 8'h00;
        byte_stb  = 1'b0;
        load_mode = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");

        // Release with load_mode=0: one IDLE cycle then RUN
        rst_n = 1'b1;
        #1 check("idle_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        @(negedge clk);
        check("run_cpu_rst_n", 64'(cpu_rst_n), 64'd1);

        // Single word
        set_mode(1'b1, 1'b0);
        send_word(32'h00100513, 1'b1);
        repeat (2) @(negedge clk);
        check("single_words_loaded", 64'(words_loaded), 64'd1);
        check("single_wr_data_hold", 64'(wr_data), 64'h00100513);
        check("single_wr_addr", 64'(wr_addr), 64'd1);
        set_mode(1'b0, 1'b1);
        check("single_partial", 64'(partial), 64'd0);
        check("run_words_hold", 64'(words_loaded), 64'd1);

        // Reload from RUN clears counters, then three back-to-back words at 0,1,2
        set_mode(1'b1, 1'b0);
        check("reload_words_cleared", 64'(words_loaded), 64'd0);
        check("reload_addr_cleared", 64'(wr_addr), 64'd0);
        send_word(32'hDEADBEEF, 1'b1);
        send_word(32'h0040006F, 1'b1);
        send_word(32'h12345678, 1'b1);
        repeat (2) @(negedge clk);
        check("three_words_loaded", 64'(words_loaded), 64'd3);
        set_mode(1'b0, 1'b1);
        check("three_partial", 64'(partial), 64'd0);

        // Partial word: one full word then two stray bytes
        set_mode(1'b1, 1'b0);
        send_word(32'hCAFEF00D, 1'b1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        set_mode(1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("partial_flag", 64'(partial), 64'd1);
        check("partial_words_loaded", 64'(words_loaded), 64'd1);
        check("partial_overflow", 64'(overflow), 64'd0);

        // Overflow: 65 words into 64 entries
        set_mode(1'b1, 1'b0);
        check("ovf_partial_cleared", 64'(partial), 64'd0);
        for (int i = 0; i < 65; i++) begin
            send_word(32'h5A000000 + 32'(i) * 32'h00010203, i < 64);
        end
        repeat (3) @(negedge clk);
        check("ovf_words_loaded", 64'(words_loaded), 64'd64);
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_addr_hold", 64'(wr_addr), 64'd63);
        check("ovf_queue_drained", 64'(exp_q.size()), 64'd0);
        set_mode(1'b0, 1'b1);
        check("ovf_flag_in_run", 64'(overflow), 64'd1);

        // Reload after overflow: flags cleared, next word to address 0
        set_mode(1'b1, 1'b0);
        check("reload2_overflow", 64'(overflow), 64'd0);
        check("reload2_words", 64'(words_loaded), 64'd0);
        send_word(32'h00000013, 1'b1);
        repeat (2) @(negedge clk);
        check("reload2_words_after", 64'(words_loaded), 64'd1);

        // Reset asserted during a write pulse
        exp_q.push_back({AW'(exp_addr), 32'h8899AABB});
        send_byte(8'hBB);
        send_byte(8'hAA);
        send_byte(8'h99);
        byte_in  = 8'h88;
        byte_stb = 1'b1;
        found    = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            @(negedge clk);
            if (wr_en === 1'b1) found = 1'b1;
        end
        check("midwrite_pulse_seen", 64'(found), 64'd1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("midwrite_reset");
        byte_stb  = 1'b0;
        load_mode = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerelease_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/imem_byte_loader.md
# imem_byte_loader

Host-to-core program loader for the pipelined RISC-V tile. It receives instruction bytes one at a time on the dedicated input pins and packs them little-endian into 32-bit words. Each completed word is written into the CPU instruction memory. The loader holds the CPU in reset while loading and releases it when the host ends the load session, which makes it the input-side counterpart of the CPU's 16-bit result output on `uo_out`/`uio_out`.

## Interface
- `WIDTH`, 32: instruction word width. Must be 32, which is exactly 4 bytes.
- `ADDR_WIDTH`, 6: instruction memory word-address width, giving 64 words.
- `clk` input 1: single clock. All state is updated on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `byte_in` input 8: instruction byte from the host (`ui_in`).
- `byte_stb` input 1: asynchronous host strobe. A rising edge means a new byte is on `byte_in`.
- `load_mode` input 1: asynchronous host level. 1 requests a load session; 0 requests run.
- `wr_en` output 1: one-cycle instruction-memory write pulse.
- `wr_addr` output ADDR_WIDTH: word address for the write.
- `wr_data` output WIDTH: assembled instruction word.
- `cpu_rst_n` output 1: active-low reset to the CPU core.
- `words_loaded` output ADDR_WIDTH+1: number of words written in the current session.
- `overflow` output 1: sticky flag. Set when a word is dropped because memory is full.
- `partial` output 1: sticky flag. Set when a session ends with 1–3 bytes pending.

## Operation
- **Synchronisers.** `byte_stb` and `load_mode` each pass through 2 flops.
  - A stb edge is detected when the synchronised `byte_stb` is 1 and its previous-cycle value was 0.
  - `byte_in` is sampled in the same cycle the edge is detected.
- **FSM states:** IDLE, LOAD, RUN. Reset state is IDLE.
- **IDLE:**
  - `cpu_rst_n`=0.
  - If synchronised `load_mode`=1, go to LOAD.
  - Else go to RUN. IDLE lasts exactly 1 cycle after reset deasserts.
- **Entering LOAD** (from IDLE or RUN):
  - Clear the byte counter, `wr_addr`, `words_loaded`, `overflow` and `partial`.
  - `cpu_rst_n`=0 for the whole of LOAD.
- **LOAD, each stb edge:**
  - Store `byte_in` into `word[8*k+7:8*k]`, where k is the byte counter (0..3). Byte 0 is the LSB.
  - k increments, wrapping 3→0.
  - On the edge that fills byte 3, the next cycle has `wr_en`=1 with `wr_data` equal to the full word and `wr_addr` equal to the current address.
  - `wr_addr` and `words_loaded` increment in the cycle after the write.
- **Memory full.** When `words_loaded` reaches 2^ADDR_WIDTH:
  - Further completed words produce no `wr_en` and set `overflow`.
  - `wr_addr` holds at 2^ADDR_WIDTH−1; it does not wrap.
- **LOAD, synchronised `load_mode`=0:** go to RUN.
  - If k≠0, the pending bytes are discarded and `partial` is set.
  - A stb edge in the same cycle is ignored.
- **RUN:**
  - `cpu_rst_n`=1, `wr_en`=0.
  - `words_loaded` and the flags hold until the next LOAD entry.
  - Synchronised `load_mode`=1 → LOAD. `cpu_rst_n` drops in that same cycle (the transition cycle).
- **Reset assertion** at any time forces all outputs to their reset values immediately, including mid-word and mid-write.

## Timing
- **Reset values:**
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cpu_rst_n`=0, `words_loaded`=0, `overflow`=0, `partial`=0.
  - FSM in IDLE, k=0.
- **Strobe latency.** The pin rise is detected 3 clk edges later (2 synchroniser flops plus the edge register).
  - The host holds `byte_in` stable from the strobe rise until at least 4 clk cycles after it.
  - Minimum strobe high time is 2 clk; minimum low time is 2 clk.
- **Write latency.** `wr_en` is asserted 1 cycle after the 4th byte is captured and is high for exactly 1 cycle.
  - `wr_data`/`wr_addr` remain valid for that cycle.
  - `wr_data` holds its last value otherwise.
- **`load_mode` latency.** A pin change takes effect on the state 3 clk edges later (2 synchroniser flops plus the state register).
  - `cpu_rst_n` changes together with the state.
- **Back-to-back bytes.** Bytes at the minimum strobe period (4 clk) must never be lost.
  - A write pulse and the next byte capture may occur in the same cycle.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-operation → all outputs at reset values in the same cycle. Release with `load_mode`=0 → RUN, `cpu_rst_n`=1 after 1 IDLE cycle.
- **Single word.** Load with bytes 0x13,0x05,0x10,0x00 → one `wr_en` pulse, `wr_addr`=0, `wr_data`=0x00100513, `words_loaded`=1.
- **Three words, then run.** Load 3 words back-to-back at the 4-clk strobe period → addresses 0,1,2, all data correct. `load_mode`=0 → `cpu_rst_n`=1 3 cycles later, `partial`=0.
- **Partial word.** Send 2 bytes, then `load_mode`=0 → no `wr_en`, `partial`=1, `words_loaded` unchanged, CPU released.
- **Overflow.** Send 65 words with ADDR_WIDTH=6 → 64 writes (last at address 63), `overflow`=1, `words_loaded`=64, no 65th `wr_en`.
- **Reload from RUN.** From RUN, raise `load_mode` → `cpu_rst_n`=0, counters and flags cleared. The next word writes to address 0.
